// File: rtl/overload_tx.sv
// overload_tx
//   Transmit side of CAN overload handling. When the frame-maker requests it,
//   this block sends one overload frame on the bus:
//     - an overload flag of FLAG_LEN dominant bits,
//     - tolerance of flag superposition from other nodes,
//     - an overload delimiter of DELIM_LEN recessive bits.
//   It drives canTX on writePoint strobes and reads canRX on samplePoint
//   strobes, both supplied by the bit-timing block.
//
// Ports
//   clock          in   system clock, all logic on rising edge
//   reset          in   asynchronous active-high reset
//   writePoint     in   strobe: canTX may change on this cycle only
//   samplePoint    in   strobe: canRX is valid on this cycle
//   canRX          in   sampled bus level (0 = dominant)
//   startOverload  in   level request to send an overload frame
//   clearCount     in   clears overloadCount
//   canTX          out  registered bus drive (0 = dominant)
//   overloadActive out  high while not IDLE
//   endOverload    out  pulse: delimiter completed correctly
//   bitError       out  pulse: recessive read back while sending the flag
//   formError      out  pulse: dominant inside the delimiter
//   stuckError     out  pulse: too many dominants after the own flag
//   overloadCount  out  overload frames started since clearCount (saturating)

module overload_tx #(
  parameter int FLAG_LEN      = 6,
  parameter int DELIM_LEN     = 8,
  parameter int MAX_SUPERPOS  = 7,
  parameter int MAX_OVERLOADS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       writePoint,
  input  logic       samplePoint,
  input  logic       canRX,
  input  logic       startOverload,
  input  logic       clearCount,
  output logic       canTX,
  output logic       overloadActive,
  output logic       endOverload,
  output logic       bitError,
  output logic       formError,
  output logic       stuckError,
  output logic [1:0] overloadCount
);

  localparam logic [3:0] FLAG_LEN_C     = 4'(FLAG_LEN);
  localparam logic [3:0] DELIM_LEN_C    = 4'(DELIM_LEN);
  localparam logic [3:0] DELIM_LAST_C   = 4'(DELIM_LEN - 1);
  localparam logic [3:0] MAX_SUPERPOS_C = 4'(MAX_SUPERPOS);
  localparam logic [1:0] MAX_OVL_C      = 2'(MAX_OVERLOADS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLAG     = 2'd1,
    WAIT_REC = 2'd2,
    DELIM    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] dom_cnt_q, dom_cnt_d;
  logic [1:0] count_q, count_d;
  logic       tx_q, tx_d;
  logic       active_q, active_d;
  logic       end_q, end_d;
  logic       bit_err_q, bit_err_d;
  logic       form_err_q, form_err_d;
  logic       stuck_err_q, stuck_err_d;

  logic       inc_s;
  logic       room_s;
  logic [3:0] bit_inc_s;
  logic [3:0] dom_inc_s;

  assign room_s    = (count_q < MAX_OVL_C);
  assign bit_inc_s = bit_cnt_q + 4'd1;
  assign dom_inc_s = dom_cnt_q + 4'd1;

  // Next-state, counter and pulse decode for the overload sequencer.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    dom_cnt_d   = dom_cnt_q;
    inc_s       = 1'b0;
    end_d       = 1'b0;
    bit_err_d   = 1'b0;
    form_err_d  = 1'b0;
    stuck_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (startOverload && room_s) begin
          state_d   = FLAG;
          bit_cnt_d = 4'd0;
          inc_s     = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end

      FLAG: begin
        if (samplePoint) begin
          if (canRX) begin
            bit_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_inc_s;
            if (bit_inc_s == FLAG_LEN_C) begin
              state_d   = WAIT_REC;
              dom_cnt_d = 4'd0;
            end else begin
              state_d   = FLAG;
            end
          end
        end else begin
          state_d = FLAG;
        end
      end

      WAIT_REC: begin
        if (samplePoint) begin
          if (!canRX) begin
            dom_cnt_d = dom_inc_s;
            if (dom_inc_s > MAX_SUPERPOS_C) begin
              stuck_err_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d     = WAIT_REC;
            end
          end else begin
            // The first recessive bit is already delimiter bit 1.
            state_d   = DELIM;
            bit_cnt_d = 4'd1;
          end
        end else begin
          state_d = WAIT_REC;
        end
      end

      DELIM: begin
        if (samplePoint) begin
          if (canRX) begin
            bit_cnt_d = bit_inc_s;
            if (bit_inc_s == DELIM_LEN_C) begin
              end_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DELIM;
            end
          end else if (bit_cnt_q == DELIM_LAST_C) begin
            // Dominant on the last delimiter bit is a fresh overload condition.
            if (room_s) begin
              state_d   = FLAG;
              bit_cnt_d = 4'd0;
              inc_s     = 1'b1;
            end else begin
              form_err_d = 1'b1;
              state_d    = IDLE;
            end
          end else begin
            form_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          state_d = DELIM;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // clearCount wins over a same-cycle increment.
    if (clearCount) begin
      count_d = 2'd0;
    end else if (inc_s && room_s) begin
      count_d = count_q + 2'd1;
    end else begin
      count_d = count_q;
    end

    // canTX follows the pre-transition state, and only on write points.
    if (writePoint) begin
      tx_d = (state_q == FLAG) ? 1'b0 : 1'b1;
    end else begin
      tx_d = tx_q;
    end

    active_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      dom_cnt_q   <= 4'd0;
      count_q     <= 2'd0;
      tx_q        <= 1'b1;
      active_q    <= 1'b0;
      end_q       <= 1'b0;
      bit_err_q   <= 1'b0;
      form_err_q  <= 1'b0;
      stuck_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      dom_cnt_q   <= dom_cnt_d;
      count_q     <= count_d;
      tx_q        <= tx_d;
      active_q    <= active_d;
      end_q       <= end_d;
      bit_err_q   <= bit_err_d;
      form_err_q  <= form_err_d;
      stuck_err_q <= stuck_err_d;
    end
  end

  assign canTX          = tx_q;
  assign overloadActive = active_q;
  assign endOverload    = end_q;
  assign bitError       = bit_err_q;
  assign formError      = form_err_q;
  assign stuckError     = stuck_err_q;
  assign overloadCount  = count_q;

endmodule

// File: tb/tb_overload_tx.sv
// tb_overload_tx
//   Directed bench for overload_tx. One bit period is four clocks: a
//   writePoint cycle, an idle cycle, a samplePoint cycle and an idle cycle.
//   By default canRX mirrors canTX; individual bits force canRX.

module tb_overload_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       writePoint;
  logic       samplePoint;
  logic       canRX;
  logic       startOverload;
  logic       clearCount;
  logic       canTX;
  logic       overloadActive;
  logic       endOverload;
  logic       bitError;
  logic       formError;
  logic       stuckError;
  logic [1:0] overloadCount;

  int total = 0;
  int bad   = 0;

  logic got_tx, got_end, got_bit, got_form, got_stuck, got_active;

  overload_tx dut (
    .clock          (clock),
    .reset          (reset),
    .writePoint     (writePoint),
    .samplePoint    (samplePoint),
    .canRX          (canRX),
    .startOverload  (startOverload),
    .clearCount     (clearCount),
    .canTX          (canTX),
    .overloadActive (overloadActive),
    .endOverload    (endOverload),
    .bitError       (bitError),
    .formError      (formError),
    .stuckError     (stuckError),
    .overloadCount  (overloadCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply strobes for one clock; outputs are read 1 ns after the edge.
  task automatic step(input logic wp, input logic sp, input logic rx);
    writePoint  = wp;
    samplePoint = sp;
    canRX       = rx;
    @(posedge clock);
    #1;
    writePoint  = 1'b0;
    samplePoint = 1'b0;
  endtask

  // One bit period; captures canTX after the write point and pulses after the sample point.
  task automatic bitp(input logic mirror, input logic rx);
    step(1'b1, 1'b0, 1'b1);
    got_tx = canTX;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, mirror ? canTX : rx);
    got_end    = endOverload;
    got_bit    = bitError;
    got_form   = formError;
    got_stuck  = stuckError;
    got_active = overloadActive;
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic start_req();
    startOverload = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    startOverload = 1'b0;
  endtask

  task automatic clear_req();
    clearCount = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    clearCount = 1'b0;
  endtask

  task automatic flag_bits(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      bitp(1'b1, 1'b1);
      if (got_tx == 1'b0 && got_bit == 1'b0 && got_active == 1'b1) n++;
    end
    check({tag, "_flag"}, 8'(n), 8'd6);
  endtask

  // Full nominal frame after a start request.
  task automatic nominal(input string tag);
    int n;
    start_req();
    flag_bits(tag);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      bitp(1'b1, 1'b1);
      if (got_tx == 1'b1 && got_end == 1'b0 && got_active == 1'b1 &&
          got_form == 1'b0 && got_stuck == 1'b0) n++;
    end
    check({tag, "_delim"}, 8'(n), 8'd7);
    bitp(1'b1, 1'b1);
    check({tag, "_end"}, {6'd0, got_end, got_active}, 8'd2);
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    writePoint    = 1'b0;
    samplePoint   = 1'b0;
    canRX         = 1'b1;
    startOverload = 1'b0;
    clearCount    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx",  {7'd0, canTX}, 8'd1);
    check("rst_outs", {2'd0, overloadActive, endOverload, bitError, formError, stuckError, 1'b0}, 8'd0);
    check("rst_cnt", {6'd0, overloadCount}, 8'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);

    // 1. Nominal frame
    start_req();
    check("t1_start", {5'd0, overloadActive, overloadCount}, 8'b0000_0101);
    check("t1_tx_pre", {7'd0, canTX}, 8'd1);
    flag_bits("t1");
    n = 0;
    for (int i = 0; i < 7; i++) begin
      bitp(1'b1, 1'b1);
      if (got_tx == 1'b1 && got_end == 1'b0 && got_active == 1'b1) n++;
    end
    check("t1_delim", 8'(n), 8'd7);
    bitp(1'b1, 1'b1);
    check("t1_end", {6'd0, got_end, got_active}, 8'd2);
    check("t1_end_width", {7'd0, endOverload}, 8'd0);
    check("t1_cnt", {6'd0, overloadCount}, 8'd1);

    // 2a. Superposition of 6 extra dominants tolerated
    clear_req();
    start_req();
    flag_bits("t2a");
    n = 0;
    for (int i = 0; i < 6; i++) begin
      bitp(1'b0, 1'b0);
      if (got_stuck == 1'b0 && got_active == 1'b1) n++;
    end
    check("t2a_superpos", 8'(n), 8'd6);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      bitp(1'b1, 1'b1);
      if (got_end == 1'b0 && got_active == 1'b1) n++;
    end
    check("t2a_delim", 8'(n), 8'd7);
    bitp(1'b1, 1'b1);
    check("t2a_end", {6'd0, got_end, got_active}, 8'd2);

    // 2b. Eight extra dominants: stuckError on the 8th
    clear_req();
    start_req();
    flag_bits("t2b");
    n = 0;
    for (int i = 0; i < 7; i++) begin
      bitp(1'b0, 1'b0);
      if (got_stuck == 1'b0 && got_active == 1'b1) n++;
    end
    check("t2b_pre", 8'(n), 8'd7);
    bitp(1'b0, 1'b0);
    check("t2b_stuck", {5'd0, got_stuck, got_active, got_end}, 8'b0000_0100);
    bitp(1'b1, 1'b1);
    check("t2b_after", {6'd0, got_end, got_active}, 8'd0);

    // 3. Bit error on the 3rd flag bit
    clear_req();
    start_req();
    bitp(1'b1, 1'b1);
    bitp(1'b1, 1'b1);
    bitp(1'b0, 1'b1);
    check("t3_biterr", {5'd0, got_bit, got_active, got_tx}, 8'b0000_0100);
    check("t3_tx_hold", {7'd0, canTX}, 8'd0);
    bitp(1'b1, 1'b1);
    check("t3_tx_rec", {6'd0, got_tx, overloadActive}, 8'd2);

    // 4a. Dominant at delimiter bit 4
    clear_req();
    start_req();
    flag_bits("t4a");
    for (int i = 0; i < 3; i++) bitp(1'b1, 1'b1);
    bitp(1'b0, 1'b0);
    check("t4a_form", {6'd0, got_form, got_active}, 8'd2);

    // 4b. Dominant at delimiter bit 8 with count=1 restarts the flag
    clear_req();
    start_req();
    flag_bits("t4b");
    for (int i = 0; i < 7; i++) bitp(1'b1, 1'b1);
    bitp(1'b0, 1'b0);
    check("t4b_restart", {6'd0, got_form, got_active}, 8'd1);
    check("t4b_cnt", {6'd0, overloadCount}, 8'd2);
    flag_bits("t4b2");
    for (int i = 0; i < 7; i++) bitp(1'b1, 1'b1);
    bitp(1'b0, 1'b0);
    check("t4c_form", {6'd0, got_form, got_active}, 8'd2);
    check("t4c_cnt", {6'd0, overloadCount}, 8'd2);

    // 5. Count limit
    clear_req();
    nominal("t5a");
    nominal("t5b");
    check("t5_cnt", {6'd0, overloadCount}, 8'd2);
    start_req();
    check("t5_ignored", {6'd0, overloadActive, canTX}, 8'd1);
    bitp(1'b1, 1'b1);
    check("t5_tx", {6'd0, got_tx, got_active}, 8'd2);
    clearCount    = 1'b1;
    startOverload = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    clearCount    = 1'b0;
    check("t5_clear", {5'd0, overloadActive, overloadCount}, 8'd0);
    step(1'b0, 1'b0, 1'b1);
    startOverload = 1'b0;
    check("t5_restart", {5'd0, overloadActive, overloadCount}, 8'b0000_0101);
    flag_bits("t5c");
    for (int i = 0; i < 7; i++) bitp(1'b1, 1'b1);
    bitp(1'b1, 1'b1);
    check("t5c_end", {6'd0, got_end, got_active}, 8'd2);

    // 6. Reset mid-flag, between write points of bit 3
    clear_req();
    start_req();
    bitp(1'b1, 1'b1);
    bitp(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("t6_tx_dom", {7'd0, canTX}, 8'd0);
    #2 reset = 1'b1;
    #1;
    check("t6_async", {1'b0, canTX, overloadActive, endOverload, bitError, formError, stuckError, 1'b0}, 8'b0100_0000);
    check("t6_cnt", {6'd0, overloadCount}, 8'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    nominal("t6");
    check("t6_cnt_after", {6'd0, overloadCount}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
